// File: rtl/preg_reclaimer.sv
`default_nettype none
// ============================================================================
// Module   : preg_reclaimer
// Purpose  : Buffers the old physical destination tags of committing
//            instructions in order, and returns them to the free list without
//            exceeding the free list's remaining space.
// Revision : 1.0 - initial release
// ============================================================================
module preg_reclaimer #(
  parameter int MAX_LENGTH = 64,
  parameter int IO_WIDTH   = 6,
  parameter int MAX_IO     = 3,
  parameter int PEND_DEPTH = 8,
  parameter int ML_BITS    = $clog2(MAX_LENGTH),
  parameter int PD_BITS    = $clog2(PEND_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MAX_IO-1:0]   commit_valid,
  input  logic [MAX_IO-1:0]   commit_has_dest,
  input  logic [IO_WIDTH-1:0] commit_old_preg [MAX_IO],
  output logic                commit_ready,
  input  logic [ML_BITS:0]    fl_len,
  output logic [MAX_IO-1:0]   put_en,
  output logic [IO_WIDTH-1:0] put [MAX_IO],
  output logic [PD_BITS-1:0]  pend_count,
  output logic [15:0]         reclaimed_total,
  output logic                overflow_err
);

  localparam logic [ML_BITS:0] C_MAX_LEN = (ML_BITS + 1)'(MAX_LENGTH);
  localparam logic [PD_BITS:0] C_MAX_IO  = (PD_BITS + 1)'(MAX_IO);
  localparam logic [PD_BITS:0] C_DEPTH   = (PD_BITS + 1)'(PEND_DEPTH);

  logic [IO_WIDTH-1:0] r_pend [PEND_DEPTH];
  logic [PD_BITS-1:0]  r_count;
  logic [15:0]         r_total;
  logic                r_ovf;

  logic [ML_BITS:0]    w_space;
  logic [PD_BITS:0]    w_count_ext;
  logic [PD_BITS:0]    w_k;
  logic [PD_BITS:0]    w_surv;
  logic [PD_BITS:0]    w_qcnt;
  logic [MAX_IO-1:0]   w_qual;
  logic [IO_WIDTH-1:0] w_q [MAX_IO];
  logic [IO_WIDTH-1:0] w_next [PEND_DEPTH];

  assign w_count_ext  = {1'b0, r_count};
  assign w_space      = (fl_len < C_MAX_LEN) ? (C_MAX_LEN - fl_len) : '0;
  assign commit_ready = (C_DEPTH - w_count_ext) >= C_MAX_IO;
  // A commit arriving while not ready is dropped entirely, so nothing qualifies.
  assign w_qual       = commit_ready ? (commit_valid & commit_has_dest) : '0;

  always_comb begin
    w_k = w_count_ext;
    if (w_k > C_MAX_IO) w_k = C_MAX_IO;
    if (32'(w_space) < 32'(w_k)) w_k = (PD_BITS + 1)'(w_space);
  end

  always_comb begin
    for (int i = 0; i < MAX_IO; i++) begin
      put_en[i] = (i < int'(w_k));
      put[i]    = put_en[i] ? r_pend[i] : '0;
    end
  end

  // Compact qualified lanes to the front, preserving lane (age) order.
  always_comb begin
    int n;
    n = 0;
    for (int j = 0; j < MAX_IO; j++) w_q[j] = '0;
    for (int i = 0; i < MAX_IO; i++) begin
      if (w_qual[i]) begin
        for (int j = 0; j < MAX_IO; j++) begin
          if (j == n) w_q[j] = commit_old_preg[i];
        end
        n = n + 1;
      end
    end
    w_qcnt = (PD_BITS + 1)'(n);
  end

  always_comb begin
    w_surv = w_count_ext - w_k;
    for (int e = 0; e < PEND_DEPTH; e++) begin
      w_next[e] = '0;
      for (int s = 0; s < PEND_DEPTH; s++) begin
        if (s < int'(w_count_ext) && s == e + int'(w_k)) w_next[e] = r_pend[s];
      end
      for (int j = 0; j < MAX_IO; j++) begin
        if (j < int'(w_qcnt) && e == int'(w_surv) + j) w_next[e] = w_q[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < PEND_DEPTH; e++) r_pend[e] <= '0;
      r_count <= '0;
      r_total <= '0;
      r_ovf   <= 1'b0;
    end else begin
      for (int e = 0; e < PEND_DEPTH; e++) r_pend[e] <= w_next[e];
      r_count <= PD_BITS'(w_surv + w_qcnt);
      r_total <= r_total + 16'(w_k);
      if (|commit_valid && !commit_ready) r_ovf <= 1'b1;
    end
  end

  assign pend_count      = r_count;
  assign reclaimed_total = r_total;
  assign overflow_err    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_preg_reclaimer.sv
`default_nettype none
// ============================================================================
// Module   : tb_preg_reclaimer
// Purpose  : Self-checking bench for preg_reclaimer with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_preg_reclaimer;

  logic       clk;
  logic       rst;
  logic [2:0] commit_valid;
  logic [2:0] commit_has_dest;
  logic [5:0] commit_old_preg [3];
  logic       commit_ready;
  logic [6:0] fl_len;
  logic [2:0] put_en;
  logic [5:0] put [3];
  logic [3:0] pend_count;
  logic [15:0] reclaimed_total;
  logic       overflow_err;

  int checks = 0;
  int errors = 0;

  int q[$];
  int m_total = 0;
  int m_ovf = 0;

  preg_reclaimer dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_has_dest(commit_has_dest),
    .commit_old_preg(commit_old_preg), .commit_ready(commit_ready),
    .fl_len(fl_len), .put_en(put_en), .put(put),
    .pend_count(pend_count), .reclaimed_total(reclaimed_total),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs computed from the queue; state advanced for the coming edge.
  always @(negedge clk) begin
    int space;
    int k;
    int ready;
    int en_exp;
    if (!rst) begin
      q.delete();
      m_total = 0;
      m_ovf = 0;
    end else begin
      space = (fl_len < 64) ? 64 - int'(fl_len) : 0;
      k = q.size();
      if (k > 3) k = 3;
      if (k > space) k = space;
      ready = ((8 - q.size()) >= 3) ? 1 : 0;
      en_exp = (1 << k) - 1;
      chk("put_en", int'(put_en), en_exp);
      for (int i = 0; i < 3; i++)
        chk($sformatf("put%0d", i), int'(put[i]), (i < k) ? q[i] : 0);
      chk("pend_count", int'(pend_count), q.size());
      chk("commit_ready", int'(commit_ready), ready);
      chk("reclaimed_total", int'(reclaimed_total), m_total);
      chk("overflow_err", int'(overflow_err), m_ovf);
      for (int i = 0; i < k; i++) void'(q.pop_front());
      m_total = (m_total + k) % 65536;
      if (commit_valid != 0) begin
        if (ready == 0) m_ovf = 1;
        else
          for (int i = 0; i < 3; i++)
            if (commit_valid[i] && commit_has_dest[i]) q.push_back(int'(commit_old_preg[i]));
      end
    end
  end

  task automatic step(input logic [2:0] v, input logic [2:0] h,
                      input int p0, input int p1, input int p2, input int fl);
    @(posedge clk);
    #1;
    commit_valid = v;
    commit_has_dest = h;
    commit_old_preg[0] = 6'(p0);
    commit_old_preg[1] = 6'(p1);
    commit_old_preg[2] = 6'(p2);
    fl_len = 7'(fl);
  endtask

  task automatic idle(input int fl);
    step(3'b000, 3'b000, 0, 0, 0, fl);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    commit_valid = '0;
    commit_has_dest = '0;
    for (int i = 0; i < 3; i++) commit_old_preg[i] = '0;
    fl_len = '0;
    #2;
    chk("rst_put_en", int'(put_en), 0);
    chk("rst_ready", int'(commit_ready), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Filter and compaction
    step(3'b111, 3'b101, 5, 9, 7, 40);
    idle(40);
    at_neg();
    chk("filt_put_en", int'(put_en), 3'b011);
    chk("filt_put0", int'(put[0]), 5);
    chk("filt_put1", int'(put[1]), 7);
    chk("filt_put2", int'(put[2]), 0);
    idle(40);
    at_neg();
    chk("filt_pend", int'(pend_count), 0);
    chk("filt_total", int'(reclaimed_total), 2);

    // Space cap
    step(3'b111, 3'b111, 1, 2, 3, 64);
    idle(63);
    at_neg();
    chk("cap_put_en", int'(put_en), 3'b001);
    chk("cap_put0", int'(put[0]), 1);
    idle(64);
    at_neg();
    chk("cap_pend", int'(pend_count), 2);
    chk("cap_full_en", int'(put_en), 0);
    idle(64);
    at_neg();
    chk("cap_hold", int'(pend_count), 2);
    repeat (3) idle(0);

    // Backpressure
    step(3'b111, 3'b111, 11, 12, 13, 64);
    step(3'b111, 3'b111, 14, 15, 16, 64);
    at_neg();
    chk("bp_pend3", int'(pend_count), 3);
    step(3'b111, 3'b111, 17, 18, 19, 64);
    at_neg();
    chk("bp_pend6", int'(pend_count), 6);
    chk("bp_ready", int'(commit_ready), 0);
    idle(64);
    at_neg();
    chk("bp_ovf", int'(overflow_err), 1);
    chk("bp_pend_hold", int'(pend_count), 6);
    idle(0);
    idle(0);
    at_neg();
    chk("bp_ovf_sticky", int'(overflow_err), 1);
    repeat (3) idle(0);

    // Asynchronous reset mid-run with 5 buffered
    step(3'b111, 3'b111, 21, 22, 23, 64);
    step(3'b011, 3'b011, 24, 25, 0, 64);
    idle(10);
    at_neg();
    chk("pre_rst_pend", int'(pend_count), 5);
    rst = 1'b0;
    #1;
    chk("arst_put_en", int'(put_en), 0);
    chk("arst_pend", int'(pend_count), 0);
    chk("arst_ready", int'(commit_ready), 1);
    chk("arst_total", int'(reclaimed_total), 0);
    chk("arst_ovf", int'(overflow_err), 0);
    idle(64);
    idle(64);
    rst = 1'b1;

    // Ordering under simultaneous emit and accept
    step(3'b111, 3'b111, 1, 2, 3, 64);
    step(3'b001, 3'b001, 4, 0, 0, 64);
    step(3'b111, 3'b111, 10, 11, 12, 0);
    at_neg();
    chk("ord1_en", int'(put_en), 3'b111);
    chk("ord1_p0", int'(put[0]), 1);
    chk("ord1_p2", int'(put[2]), 3);
    idle(0);
    at_neg();
    chk("ord2_p0", int'(put[0]), 4);
    chk("ord2_p1", int'(put[1]), 10);
    chk("ord2_p2", int'(put[2]), 11);
    idle(0);
    at_neg();
    chk("ord3_en", int'(put_en), 3'b001);
    chk("ord3_p0", int'(put[0]), 12);
    idle(0);
    at_neg();
    chk("ord_total", int'(reclaimed_total), 7);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      int fl;
      r = $urandom_range(0, 9);
      if (r < 3) fl = 64;
      else if (r < 5) fl = $urandom_range(60, 63);
      else fl = $urandom_range(0, 64);
      step(3'($urandom), 3'($urandom), $urandom_range(0, 63),
           $urandom_range(0, 63), $urandom_range(0, 63), fl);
    end
    repeat (4) idle(0);

    // Counter wrap
    pulse_reset();
    for (int n = 0; n < 21844; n++) step(3'b111, 3'b111, n % 64, (n + 1) % 64, (n + 2) % 64, 0);
    step(3'b011, 3'b011, 33, 34, 0, 0);
    repeat (3) idle(0);
    at_neg();
    chk("wrap_pre", int'(reclaimed_total), 65534);
    step(3'b111, 3'b111, 40, 41, 42, 0);
    repeat (3) idle(0);
    at_neg();
    chk("wrap_post", int'(reclaimed_total), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
